// File: rtl/line_fetcher.sv
// Line fetcher: splits a word request into line address + word index, reads one line, presents it downstream.
// Optional macro LINE_FETCH_REUSE_EN skips the memory read when the request hits the last fetched line.
module line_fetcher #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64,
    parameter int ADDR_W     = 64,
    parameter int IDX_W      = 3,
    parameter int OFF_W      = 6,
    parameter int WOFF_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  mem_rd_valid,
    input  logic                  mem_rd_ready,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic                  mem_resp_valid,
    input  logic [FULL_WIDTH-1:0] mem_resp_data,
    output logic                  line_valid,
    input  logic                  line_ready,
    output logic [FULL_WIDTH-1:0] line_data,
    output logic [IDX_W-1:0]      line_idx
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PRESENT} state_t;

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_mem_rd_valid;
    logic [ADDR_W-1:0]       r_mem_rd_addr;
    logic                    r_line_valid;
    logic [FULL_WIDTH-1:0]   r_line_data;
    logic [IDX_W-1:0]        r_line_idx;

    logic [ADDR_W-1:0]       w_line_addr;
    logic [IDX_W-1:0]        w_req_idx;
    logic                    w_unused_woff;

    assign w_line_addr   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_req_idx     = req_addr[OFF_W-1:WOFF_W];
    // Byte offset within a word is deliberately dropped; misaligned requests are not an error.
    assign w_unused_woff = ^req_addr[WOFF_W-1:0];

`ifdef LINE_FETCH_REUSE_EN
    logic [ADDR_W-OFF_W-1:0] r_tag;
    logic                    r_tag_valid;
    logic                    w_hit;

    assign w_hit = r_tag_valid && (r_tag == req_addr[ADDR_W-1:OFF_W]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_req_ready    <= 1'b1;
            r_mem_rd_valid <= 1'b0;
            r_mem_rd_addr  <= '0;
            r_line_valid   <= 1'b0;
            r_line_data    <= '0;
            r_line_idx     <= '0;
`ifdef LINE_FETCH_REUSE_EN
            r_tag          <= '0;
            r_tag_valid    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_mem_rd_addr <= w_line_addr;
                        r_line_idx    <= w_req_idx;
                        r_req_ready   <= 1'b0;
`ifdef LINE_FETCH_REUSE_EN
                        if (w_hit) begin
                            r_line_valid <= 1'b1;
                            r_state      <= PRESENT;
                        end else begin
                            r_mem_rd_valid <= 1'b1;
                            r_state        <= ISSUE;
                        end
`else
                        r_mem_rd_valid <= 1'b1;
                        r_state        <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    if (mem_rd_ready) begin
                        r_mem_rd_valid <= 1'b0;
                        r_state        <= WAIT;
                    end
                end
                WAIT: begin
                    // Responses are only trusted here; anything seen in other states is stale or spurious.
                    if (mem_resp_valid) begin
                        r_line_data  <= mem_resp_data;
                        r_line_valid <= 1'b1;
                        r_state      <= PRESENT;
`ifdef LINE_FETCH_REUSE_EN
                        r_tag        <= r_mem_rd_addr[ADDR_W-1:OFF_W];
                        r_tag_valid  <= 1'b1;
`endif
                    end
                end
                PRESENT: begin
                    if (line_ready) begin
                        r_line_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign mem_rd_valid = r_mem_rd_valid;
    assign mem_rd_addr  = r_mem_rd_addr;
    assign line_valid   = r_line_valid;
    assign line_data    = r_line_data;
    assign line_idx     = r_line_idx;

endmodule

// File: tb/tb_line_fetcher.sv
// Randomized scoreboard bench for line_fetcher: a memory model, a downstream consumer and a line-level reference model.
// Building with LINE_FETCH_REUSE_EN defined switches the reference model to expect line reuse.
module tb_line_fetcher;

    localparam int FULL_WIDTH = 512;
    localparam int ADDR_W     = 64;
    localparam int IDX_W      = 3;

`ifdef LINE_FETCH_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  mem_rd_valid;
    logic                  mem_rd_ready;
    logic [ADDR_W-1:0]     mem_rd_addr;
    logic                  mem_resp_valid;
    logic [FULL_WIDTH-1:0] mem_resp_data;
    logic                  line_valid;
    logic                  line_ready;
    logic [FULL_WIDTH-1:0] line_data;
    logic [IDX_W-1:0]      line_idx;

    line_fetcher dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_ready   (mem_rd_ready),
        .mem_rd_addr    (mem_rd_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .line_valid     (line_valid),
        .line_ready     (line_ready),
        .line_data      (line_data),
        .line_idx       (line_idx)
    );

    typedef struct {
        logic [FULL_WIDTH-1:0] data;
        logic [IDX_W-1:0]      idx;
    } exp_t;

    exp_t              expQ[$];
    logic [ADDR_W-1:0] readQ[$];

    int total = 0;
    int bad   = 0;

    int mrProb   = 100;
    int lrProb   = 100;
    bit spurEn   = 0;
    bit memHold  = 0;
    bit memPending = 0;
    int readCount  = 0;

    bit                    tagValid = 0;
    logic [ADDR_W-1:0]     tag      = '0;
    logic [FULL_WIDTH-1:0] lastData;
    logic [IDX_W-1:0]      lastIdx;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Memory content: word k of the line at address A is {A[55:0], 0xA0+k}.
    function automatic logic [FULL_WIDTH-1:0] lineOf(input logic [ADDR_W-1:0] la);
        logic [FULL_WIDTH-1:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = {la[55:0], 8'hA0 + 8'(k)};
        return l;
    endfunction

    task automatic checkOutput(input string name, input logic [FULL_WIDTH-1:0] act,
                               input logic [FULL_WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst req_ready", req_ready, 1);
        checkOutput("rst mem_rd_valid", mem_rd_valid, 0);
        checkOutput("rst line_valid", line_valid, 0);
        checkOutput("rst mem_rd_addr", mem_rd_addr, 0);
        checkOutput("rst line_data", line_data, 0);
        checkOutput("rst line_idx", line_idx, 0);
    endtask

    // Issue one request; the reference model decides line address, index and whether a read is due.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] lineA;
        bit hit;
        int waited;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1;
        req_addr  = addr;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("req accept timeout", 0, 1);
            req_valid = 0;
            return;
        end
        lineA = addr & ~64'h3F;
        hit   = REUSE && tagValid && (tag == lineA);
        if (!hit) begin
            readQ.push_back(lineA);
            tagValid = 1;
            tag      = lineA;
        end
        e.data = lineOf(lineA);
        e.idx  = addr[5:3];
        expQ.push_back(e);
        @(posedge clk); #1;
        req_valid = 0;
        req_addr  = {$urandom, $urandom};
        @(negedge clk);
        if (hit) checkOutput("reuse line_valid latency", line_valid, 1);
        else     checkOutput("mem_rd_valid latency", mem_rd_valid, 1);
        checkOutput("req_ready busy", req_ready, 0);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || readQ.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0 || readQ.size() != 0) checkOutput("drain timeout", 0, 1);
    endtask

    // Memory model: random read backpressure, random response delay, optional spurious responses.
    initial begin
        logic [ADDR_W-1:0] respLine;
        int delay;
        bit respShown;
        bit armed;
        mem_rd_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        respLine = '0; delay = 0; respShown = 0; armed = 0;
        forever begin
            @(posedge clk); #1;
            mem_rd_ready   = ($urandom_range(0, 99) < mrProb);
            mem_resp_valid = 0;
            respShown      = 0;
            if (memPending) begin
                if (delay == 0 && !memHold) begin
                    mem_resp_valid = 1;
                    mem_resp_data  = lineOf(respLine);
                    memPending     = 0;
                    respShown      = 1;
                end else if (delay > 0) begin
                    delay--;
                end
            end else if (spurEn && $urandom_range(0, 3) == 0) begin
                mem_resp_valid = 1;
                mem_resp_data  = {16{$urandom}};
            end
            @(negedge clk);
            if (!rst_n) begin
                memPending = 0;
                armed      = 0;
                continue;
            end
            if (armed) begin
                checkOutput("line_valid after resp", line_valid, 1);
                armed = 0;
            end
            if (respShown) armed = 1;
            if (mem_rd_valid) begin
                if (readQ.size() == 0) begin
                    checkOutput("unexpected read", 1, 0);
                end else begin
                    checkOutput("mem_rd_addr", mem_rd_addr, readQ[0]);
                    if (mem_rd_ready) begin
                        respLine   = readQ.pop_front();
                        memPending = 1;
                        delay      = $urandom_range(0, 3);
                        readCount++;
                    end
                end
            end
        end
    end

    initial begin
        line_ready = 0;
        forever begin
            @(posedge clk); #1;
            line_ready = ($urandom_range(0, 99) < lrProb);
        end
    end

    // Monitor: every cycle a line is presented it must equal the scoreboard head; pop on handshake.
    initial begin
        lastData = '0;
        lastIdx  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (line_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected line", 1, 0);
                end else begin
                    checkOutput("line_data", line_data, expQ[0].data);
                    checkOutput("line_idx", line_idx, expQ[0].idx);
                    checkOutput("req_ready while presenting", req_ready, 0);
                    if (line_ready) begin
                        lastData = line_data;
                        lastIdx  = line_idx;
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int r0;
        int n;
        logic [ADDR_W-1:0] bases[4];
        logic [ADDR_W-1:0] a;
        bases[0] = 64'h1040; bases[1] = 64'h2000;
        bases[2] = 64'h7FC0; bases[3] = 64'hFFFF_FFFF_FFFF_FFC0;
        rst_n = 0; req_valid = 0; req_addr = '0;
        repeat (3) @(posedge clk);
        #1 checkResetOutputs();
        #2 rst_n = 1;

        applyStimulus(64'h1048);
        waitDrain();
        checkOutput("basic idx", lastIdx, 1);
        checkOutput("basic word-select byte", lastData[64 +: 8], 8'hA1);

        applyStimulus(64'h2000);
        waitDrain();
        checkOutput("boundary idx0", lastIdx, 0);
        applyStimulus(64'h203F);
        waitDrain();
        checkOutput("boundary idx7", lastIdx, 7);

        mrProb = 0;
        lrProb = 0;
        applyStimulus(64'h3010);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rd held valid", mem_rd_valid, 1);
        end
        mrProb = 100;
        n = 0;
        while (!line_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("line_valid arrives", line_valid, 1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("line held valid", line_valid, 1);
            checkOutput("req_ready held low", req_ready, 0);
        end
        lrProb = 100;
        waitDrain();

        spurEn = 1;
        mrProb = 30;
        applyStimulus(64'h6028);
        waitDrain();
        repeat (10) @(negedge clk);
        checkOutput("idle line_data after spurious", line_data, lineOf(tag));
        checkOutput("idle line_valid", line_valid, 0);
        spurEn = 0;
        mrProb = 100;

        r0 = readCount;
        applyStimulus(64'h1048);
        applyStimulus(64'h1078);
        waitDrain();
        checkOutput("reuse idx", lastIdx, 7);
        checkOutput("reuse read count", readCount - r0, REUSE ? 1 : 2);

        memHold = 1;
        applyStimulus(64'h4008);
        n = 0;
        while (!memPending && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached wait", memPending, 1);
        #2 rst_n = 0;
        #1 checkResetOutputs();
        expQ.delete();
        readQ.delete();
        tagValid = 0;
        repeat (2) @(posedge clk);
        #3 memHold = 0;
        rst_n = 1;
        @(negedge clk);
        checkOutput("req_ready after reset", req_ready, 1);
        applyStimulus(64'h5050);
        waitDrain();
        checkOutput("post-reset idx", lastIdx, 2);

        mrProb = 60;
        lrProb = 60;
        spurEn = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) a = {$urandom, $urandom};
            else a = bases[$urandom_range(0, 3)] | 64'($urandom_range(0, 63));
            applyStimulus(a);
        end
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
